acia_rx: RTL
============

// Module: acia_rx
// PURPOSE
// - Receive half of the ACIA 6551: deserialises asynchronous serial data on rxd into the receive data register.
// - Runs on xtli, gated by a 16x-oversampled baud enable from the receive-side baud generator; the transmit side already has its own tx clock generator.
// - Reports RDRF, framing, parity and overrun status to the ACIA register/status logic. CPU reads of RDR are signalled by rd_strobe.
// PARAMETERS
// - OVERSAMPLE   16  rx_tick_16x pulses per bit period; must be even, >= 4.
// - SYNC_STAGES  2   flops in the rxd metastability synchroniser, >= 2.
// PORTS
// - xtli              in   1  system/crystal clock; all logic on posedge.
// - reset             in   1  reset, synchronous, active-high.
// - rx_tick_16x       in   1  one-xtli-cycle enable, OVERSAMPLE per bit period.
// - rxd               in   1  asynchronous serial input; idle high.
// - word_length       in   2  00=8, 01=7, 10=6, 11=5 data bits.
// - parity_enable     in   1  1 = a parity bit follows the data bits.
// - parity_mode       in   2  00 odd, 01 even, 10 mark (bit must be 1), 11 space (bit must be 0).
// - rd_strobe         in   1  one-cycle pulse: CPU read RDR this cycle.
// - rx_data           out  8  received word, LSB-aligned; unused upper bits are 0.
// - rdrf              out  1  receive data register full.
// - framing_err       out  1  stop bit of the word in rx_data sampled low.
// - parity_err        out  1  parity check of the word in rx_data failed.
// - overrun           out  1  a word completed while rdrf=1 and was discarded.
// - rx_busy           out  1  1 in every state except IDLE.
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; synchroniser flops and prev-sample register set to 1 (idle line).
// - rxd passes through SYNC_STAGES flops; the FSM sees only rxd_s. The FSM advances only on cycles with rx_tick_16x=1.
// - Counters: tick_cnt counts 0..OVERSAMPLE-1 and wraps; bit_cnt counts received data bits.
// - IDLE: on a tick with prev rxd_s=1 and rxd_s=0 (falling edge) -> START, tick_cnt=0. A line held low produces no edge and does not retrigger.
// - START: on tick OVERSAMPLE/2-1 (mid start bit) sample: if rxd_s=1, false start -> IDLE; if 0 -> DATA, tick_cnt=0, bit_cnt=0.
// - DATA: sample on every tick_cnt=OVERSAMPLE-1 (mid bit), shift in LSB first. After N bits (N from word_length): if parity_enable -> PARITY, else -> STOP.
// - PARITY: sample one bit. Odd: data^bit must be 1. Even: must be 0. Mark: bit must be 1. Space: bit must be 0. The result is held until load.
// - STOP: sample one bit; stop_ok = rxd_s. On the same cycle as this sample, the word is loaded (see below) and the FSM returns to IDLE. Only the first stop bit is checked.
// - Load, registered (outputs change on the cycle after the stop-sample tick):
//   - If rdrf=0, or rd_strobe=1 on that cycle: rx_data=word zero-extended; rdrf=1; framing_err=~stop_ok; parity_err=parity fail (0 if parity disabled); overrun=0.
//   - Otherwise: overrun=1; rx_data, framing_err, parity_err and rdrf are unchanged; the word is discarded.
// - rd_strobe with no load on the same cycle: rdrf, overrun, framing_err and parity_err clear to 0; rx_data is held.
// - word_length, parity_enable and parity_mode are sampled on the IDLE->START transition and held for the whole frame.
// - reset asserted mid-frame: the frame is abandoned; all state returns to reset values on the next edge; no partial load.
// - Latency: an rxd edge reaches rxd_s after SYNC_STAGES cycles. rdrf rises 1 xtli cycle after the mid-stop-bit tick.
// TESTING
// - Setup for all scenarios: tick every cycle, OVERSAMPLE=16, unless stated otherwise.
// - 1. 8N1, send 0xA5 -> rx_data=0xA5, rdrf=1, all errors 0. Then rd_strobe -> rdrf=0, rx_data still 0xA5.
// - 2. 7E1, send 0x41 with correct even parity bit, then the same frame with the bit flipped -> first parity_err=0; second (after read) parity_err=1, rx_data=0x41.
// - 3. 5-bit, no parity, send 0x1F with stop bit forced low -> rx_data=0x1F, framing_err=1. Hold rxd low for 40 bit times -> no further frames.
// - 4. Glitch: low pulse of 4 ticks on idle line -> FSM returns to IDLE, rdrf stays 0.
// - 5. Send 0x11 then 0x22 without a read -> overrun=1, rx_data=0x11. Repeat with rd_strobe on the load cycle -> rx_data=0x22, overrun=0, rdrf=1.
// - 6. Assert reset at data bit 3 of a frame -> all outputs 0 next cycle; the following clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/acia_rx.sv
// acia_rx -- receive half of the ACIA 6551.
//
// Deserialises asynchronous serial data on rxd into the receive data register
// and reports RDRF, framing, parity and overrun status. All logic runs on xtli
// and the FSM advances only on cycles where rx_tick_16x is high.
//
// Ports:
//   xtli          in   system/crystal clock, posedge
//   reset         in   synchronous, active-high
//   rx_tick_16x   in   one-cycle enable, OVERSAMPLE pulses per bit period
//   rxd           in   asynchronous serial input, idle high
//   word_length   in   00=8, 01=7, 10=6, 11=5 data bits
//   parity_enable in   a parity bit follows the data bits
//   parity_mode   in   00 odd, 01 even, 10 mark, 11 space
//   rd_strobe     in   CPU read of RDR this cycle
//   rx_data       out  received word, LSB-aligned, upper bits zero
//   rdrf          out  receive data register full
//   framing_err   out  stop bit of the word in rx_data sampled low
//   parity_err    out  parity check of the word in rx_data failed
//   overrun       out  a word completed while rdrf=1 and was discarded
//   rx_busy       out  receiver is not idle
module acia_rx #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       xtli,
    input  logic       reset,
    input  logic       rx_tick_16x,
    input  logic       rxd,
    input  logic [1:0] word_length,
    input  logic       parity_enable,
    input  logic [1:0] parity_mode,
    input  logic       rd_strobe,
    output logic [7:0] rx_data,
    output logic       rdrf,
    output logic       framing_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic                   prev_q;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_acc_q, par_acc_d;
    logic                   par_fail_q, par_fail_d;
    logic [1:0]             wl_q, wl_d;
    logic                   pe_q, pe_d;
    logic [1:0]             pm_q, pm_d;
    logic [2:0]             last_bit;
    logic                   load;

    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rdrf_q, rdrf_d;
    logic                   fe_q, fe_d;
    logic                   perr_q, perr_d;
    logic                   ovr_q, ovr_d;

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign last_bit = 3'd7 - {1'b0, wl_q};

    // Frame FSM and datapath next-state.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_fail_d = par_fail_q;
        wl_d       = wl_q;
        pe_d       = pe_q;
        pm_d       = pm_q;
        load       = 1'b0;

        if (rx_tick_16x) begin
            tick_cnt_d = (tick_cnt_q == LAST) ? '0 : tick_cnt_q + TW'(1);
            unique case (state_q)
                S_IDLE: begin
                    // Edge-triggered: a line stuck low never restarts a frame.
                    if (prev_q && !rxd_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                        wl_d       = word_length;
                        pe_d       = parity_enable;
                        pm_d       = parity_mode;
                        shift_d    = '0;
                        par_acc_d  = 1'b0;
                        par_fail_d = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == MID) begin
                        state_d    = rxd_s ? S_IDLE : S_DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == LAST) begin
                        shift_d[bit_cnt_q] = rxd_s;
                        par_acc_d          = par_acc_q ^ rxd_s;
                        if (bit_cnt_q == last_bit) begin
                            state_d = pe_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == LAST) begin
                        unique case (pm_q)
                            2'b00:   par_fail_d = ~(par_acc_q ^ rxd_s);
                            2'b01:   par_fail_d = par_acc_q ^ rxd_s;
                            2'b10:   par_fail_d = ~rxd_s;
                            default: par_fail_d = rxd_s;
                        endcase
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == LAST) begin
                        load    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Receive register and status. A read coinciding with a load frees the
    // register for the incoming word instead of flagging an overrun.
    always_comb begin
        rx_data_d = rx_data_q;
        rdrf_d    = rdrf_q;
        fe_d      = fe_q;
        perr_d    = perr_q;
        ovr_d     = ovr_q;
        if (load) begin
            if (!rdrf_q || rd_strobe) begin
                rx_data_d = shift_q;
                rdrf_d    = 1'b1;
                fe_d      = ~rxd_s;
                perr_d    = par_fail_q;
                ovr_d     = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_strobe) begin
            rdrf_d = 1'b0;
            fe_d   = 1'b0;
            perr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge xtli) begin
        if (reset) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_fail_q <= 1'b0;
            wl_q       <= '0;
            pe_q       <= 1'b0;
            pm_q       <= '0;
            rx_data_q  <= '0;
            rdrf_q     <= 1'b0;
            fe_q       <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
            if (rx_tick_16x) begin
                prev_q <= rxd_s;
            end
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            par_fail_q <= par_fail_d;
            wl_q       <= wl_d;
            pe_q       <= pe_d;
            pm_q       <= pm_d;
            rx_data_q  <= rx_data_d;
            rdrf_q     <= rdrf_d;
            fe_q       <= fe_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rdrf        = rdrf_q;
    assign framing_err = fe_q;
    assign parity_err  = perr_q;
    assign overrun     = ovr_q;
    assign rx_busy     = (state_q != S_IDLE);

endmodule
